gcd_ctrl: RTL and testbench

//  Sequencing FSM for the subtractive GCD datapath (gcd_datapath). Owns the two operand

---
 rtl/gcd_pkg.sv | 22 ++
 rtl/gcd_ctrl.sv | 136 +++++++++++++
 tb/tb_gcd_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared encodings for the subtractive GCD controller and its datapath.
//   - dp_ctrl op codes understood by gcd_datapath
//   - controller state enum
package gcd_pkg;

  localparam logic [2:0] CMP_EQ    = 3'd0;  // dp_cmp = (A == B)
  localparam logic [2:0] CMP_A     = 3'd1;  // dp_cmp = (A >  B)
  localparam logic [2:0] OP_A      = 3'd2;  // dp_out = A - B
  localparam logic [2:0] OP_B      = 3'd3;  // dp_out = B - A
  localparam logic [2:0] OP_DONE   = 3'd4;  // dp_out = A
  localparam logic [2:0] CTRL_IDLE = 3'd5;  // datapath unused

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_EQ,
    S_CHK_GT,
    S_SUB_A,
    S_SUB_B,
    S_FIN
  } state_t;

endpackage

// File: rtl/gcd_ctrl.sv
// Sequencing FSM for the subtractive GCD datapath.
// Owns the A/B operand registers, steps the datapath through
// compare / subtract / done codes until A==B, and reports the result
// through a start/done handshake. Zero operands bypass the datapath;
// an iteration limit aborts runaway sequences with err=1.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start, a_in, b_in host request and operands (sampled in IDLE only)
//   busy              high from the cycle after accept until done
//   done              one-cycle pulse; result/err valid (held until next accept)
//   result, err       gcd value / error flag (both-zero or iteration limit)
//   dp_a, dp_b        operand registers driven to the datapath
//   dp_ctrl           datapath op code (Moore, decoded from state)
//   dp_cmp, dp_out    combinational datapath compare flag / arithmetic result
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int OP_SZ    = 8,
  parameter int MAX_ITER = 2**OP_SZ-1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OP_SZ-1:0] a_in,
  input  logic [OP_SZ-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [OP_SZ-1:0] result,
  output logic             err,
  output logic [OP_SZ-1:0] dp_a,
  output logic [OP_SZ-1:0] dp_b,
  output logic [2:0]       dp_ctrl,
  input  logic             dp_cmp,
  input  logic [OP_SZ-1:0] dp_out
);

  localparam logic [OP_SZ-1:0] ITER_LIM = OP_SZ'(MAX_ITER);

  state_t           state, state_nxt;
  logic [OP_SZ-1:0] iter;
  logic             zero_op;
  logic             at_lim;

  // Either operand zero: answer is the other one, no datapath work needed.
  assign zero_op = (a_in == '0) || (b_in == '0);
  assign at_lim  = (iter == ITER_LIM);

  always_comb begin
    state_nxt = state;
    dp_ctrl   = CTRL_IDLE;
    case (state)
      S_IDLE: begin
        if (start && !zero_op) state_nxt = S_CHK_EQ;
      end
      S_CHK_EQ: begin
        dp_ctrl   = CMP_EQ;
        state_nxt = dp_cmp ? S_FIN : S_CHK_GT;
      end
      S_CHK_GT: begin
        dp_ctrl = CMP_A;
        if (at_lim)      state_nxt = S_IDLE;
        else if (dp_cmp) state_nxt = S_SUB_A;
        else             state_nxt = S_SUB_B;
      end
      S_SUB_A: begin
        dp_ctrl   = OP_A;
        state_nxt = S_CHK_EQ;
      end
      S_SUB_B: begin
        dp_ctrl   = OP_B;
        state_nxt = S_CHK_EQ;
      end
      S_FIN: begin
        dp_ctrl   = OP_DONE;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      dp_a   <= '0;
      dp_b   <= '0;
      iter   <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            dp_a <= a_in;
            dp_b <= b_in;
            iter <= '0;
            err  <= 1'b0;
            if (zero_op) begin
              done   <= 1'b1;
              result <= a_in | b_in;
              err    <= (a_in == '0) && (b_in == '0);
            end else begin
              busy <= 1'b1;
            end
          end
        end
        S_CHK_GT: begin
          if (at_lim) begin
            done   <= 1'b1;
            err    <= 1'b1;
            result <= '0;
            busy   <= 1'b0;
          end
        end
        S_SUB_A: begin
          dp_a <= dp_out;
          iter <= iter + 1'b1;
        end
        S_SUB_B: begin
          dp_b <= dp_out;
          iter <= iter + 1'b1;
        end
        S_FIN: begin
          result <= dp_out;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
module tb_gcd_ctrl;
  import gcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  // main instance, default iteration limit
  logic       start;
  logic [7:0] a_in, b_in;
  logic       busy, done, err, dp_cmp;
  logic [7:0] result, dp_a, dp_b, dp_out;
  logic [2:0] dp_ctrl;
  // second instance, iteration limit 4
  logic       start1;
  logic [7:0] a1, b1;
  logic       busy1, done1, err1, dp_cmp1;
  logic [7:0] result1, dp_a1, dp_b1, dp_out1;
  logic [2:0] dp_ctrl1;

  always #5 clk = ~clk;

  gcd_ctrl #(.OP_SZ(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .result(result), .err(err),
    .dp_a(dp_a), .dp_b(dp_b), .dp_ctrl(dp_ctrl), .dp_cmp(dp_cmp), .dp_out(dp_out));

  gcd_ctrl #(.OP_SZ(8), .MAX_ITER(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a1), .b_in(b1),
    .busy(busy1), .done(done1), .result(result1), .err(err1),
    .dp_a(dp_a1), .dp_b(dp_b1), .dp_ctrl(dp_ctrl1), .dp_cmp(dp_cmp1), .dp_out(dp_out1));

  // Behavioural datapath for each instance.
  always_comb begin
    dp_cmp = 1'b0;
    dp_out = '0;
    case (dp_ctrl)
      CMP_EQ:  dp_cmp = (dp_a == dp_b);
      CMP_A:   dp_cmp = (dp_a > dp_b);
      OP_A:    dp_out = dp_a - dp_b;
      OP_B:    dp_out = dp_b - dp_a;
      OP_DONE: dp_out = dp_a;
      default: ;
    endcase
  end

  always_comb begin
    dp_cmp1 = 1'b0;
    dp_out1 = '0;
    case (dp_ctrl1)
      CMP_EQ:  dp_cmp1 = (dp_a1 == dp_b1);
      CMP_A:   dp_cmp1 = (dp_a1 > dp_b1);
      OP_A:    dp_out1 = dp_a1 - dp_b1;
      OP_B:    dp_out1 = dp_b1 - dp_a1;
      OP_DONE: dp_out1 = dp_a1;
      default: ;
    endcase
  end

  typedef struct {
    int res;
    int err;
    int k;
    int dcyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   free_at = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;
  int   sub_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: Euclid by repeated subtraction, counting subtractions,
  // giving up when the subtraction budget is spent and A!=B remains.
  function automatic void ref_gcd(input int a, input int b, input int maxit,
                                  output int r, output int e, output int k);
    k = 0;
    e = 0;
    r = 0;
    if (a == 0 || b == 0) begin
      r = a | b;
      e = (a == 0 && b == 0) ? 1 : 0;
      return;
    end
    while (a != b) begin
      if (k == maxit) begin
        r = 0;
        e = 1;
        return;
      end
      if (a > b) a -= b;
      else       b -= a;
      k++;
    end
    r = a;
  endfunction

  // Monitor: busy window every cycle, scoreboard pop on every done.
  always @(negedge clk) begin
    exp_t e;
    if (dp_ctrl == OP_A || dp_ctrl == OP_B) sub_cnt++;
    if (rst) begin
      sub_cnt = 0;
    end else begin
      chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", int'(result), e.res);
          chk("err", int'(err), e.err);
          chk("done cycle", cyc, e.dcyc);
          chk("subtract codes", sub_cnt, e.k);
        end
        sub_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    start  = 1'b0;
    start1 = 1'b0;
  endtask

  // Wait until the model says the DUT is idle, then issue one request.
  // With noise set, ignored starts carrying junk operands are thrown in
  // while the previous request is still running.
  task automatic go(input int a, input int b, input bit noise);
    exp_t e;
    int   lat;
    while (cyc < free_at) begin
      if (noise && $urandom_range(0, 3) == 0) begin
        start = 1'b1;
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
      end
      step();
    end
    ref_gcd(a, b, 255, e.res, e.err, e.k);
    lat    = (a == 0 || b == 0) ? 1 : 3 * e.k + 3;
    e.dcyc = cyc + lat;
    q.push_back(e);
    free_at = cyc + lat;
    busy_lo = cyc + 1;
    busy_hi = cyc + lat - 1;
    start = 1'b1;
    a_in  = 8'(a);
    b_in  = 8'(b);
    step();
  endtask

  initial begin
    int c0;
    int t;
    int ra, rb, mode;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    step(); step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset err", int'(err), 0);
    chk("reset result", int'(result), 0);
    chk("reset dp_a", int'(dp_a), 0);
    chk("reset dp_b", int'(dp_b), 0);
    chk("reset dp_ctrl", int'(dp_ctrl), 5);
    step();
    free_at = cyc;

    go(12, 8, 0);
    go(37, 37, 0);
    go(0, 21, 0);
    go(0, 0, 0);
    go(255, 1, 0);
    // Junk start mid-run, then a back-to-back start on the done cycle.
    go(48, 18, 0);
    step();
    start = 1'b1; a_in = 8'd9; b_in = 8'd6;
    step();
    go(9, 6, 0);

    // Synchronous reset during cycle 4 of a run: no done may follow.
    go(48, 18, 0);
    step(); step();
    rst = 1'b1;
    q.delete();
    busy_hi = cyc;
    step();
    rst = 1'b0;
    free_at = cyc;
    @(negedge clk);
    chk("busy after reset", int'(busy), 0);
    step();
    free_at = cyc;
    go(48, 18, 0);

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 9);
      ra = $urandom_range(1, 255);
      rb = $urandom_range(1, 255);
      case (mode)
        0: ra = 0;
        1: rb = 0;
        2: rb = ra;
        3: begin ra = $urandom_range(1, 15); rb = $urandom_range(1, 15); end
        default: ;
      endcase
      go(ra, rb, 1);
      repeat ($urandom_range(0, 2)) step();
    end

    t = 0;
    while (q.size() > 0 && t < 2000) begin
      step();
      t++;
    end
    chk("scoreboard drained", q.size(), 0);

    // Iteration limit of 4 on the second instance.
    start1 = 1'b1; a1 = 8'd255; b1 = 8'd1;
    c0 = cyc;
    step();
    t = 0;
    @(negedge clk);
    while (!done1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("limit done seen", int'(done1), 1);
    chk("limit err", int'(err1), 1);
    chk("limit result", int'(result1), 0);
    chk("limit done cycle", cyc, c0 + 15);
    step();
    start1 = 1'b1; a1 = 8'd12; b1 = 8'd8;
    c0 = cyc;
    step();
    t = 0;
    @(negedge clk);
    while (!done1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("limit4 12,8 done seen", int'(done1), 1);
    chk("limit4 12,8 result", int'(result1), 4);
    chk("limit4 12,8 err", int'(err1), 0);
    chk("limit4 12,8 done cycle", cyc, c0 + 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
